// File: rtl/hold_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hold_ctrl_pkg : shared state encodings and defaults for hold_ctrl     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hold_ctrl_pkg;

   typedef enum logic [1:0] {
      HC_RUN   = 2'd0,
      HC_FLUSH = 2'd1,
      HC_PEND  = 2'd2
   } hc_state_t;

   localparam int HC_FLUSH_CYCLES_DEF = 2;
   localparam int HC_CNT_W            = 3;

endpackage : hold_ctrl_pkg
`default_nettype wire

// File: rtl/hold_ctrl_redir_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hold_ctrl_redir_buf : one-entry buffer for a redirect seen while frozen|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hold_ctrl_redir_buf #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_clear,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_addr  <= i_addr;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
      end
   end

   assign o_valid = r_valid;
   assign o_addr  = r_addr;

endmodule : hold_ctrl_redir_buf
`default_nettype wire

// File: rtl/hold_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hold_ctrl : merges jump, interrupt and stall sources into PC redirect,|
// |             per-stage holds and a multi-cycle flush window. Rev 1.0   |
// +----------------------------------------------------------------------+
module hold_ctrl
   import hold_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = HC_FLUSH_CYCLES_DEF,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hc_jump_flag_in,
   input  logic [ADDR_W-1:0] hc_jump_addr_in,
   input  logic              hc_irq_flag_in,
   input  logic [ADDR_W-1:0] hc_irq_addr_in,
   output logic              hc_irq_ack_out,
   input  logic              hc_mem_busy_in,
   input  logic              hc_div_busy_in,
   output logic              hc_jump_flag_out,
   output logic [ADDR_W-1:0] hc_jump_addr_out,
   output logic              hc_hold_pc_out,
   output logic              hc_hold_if_out,
   output logic              hc_hold_id_out,
   output logic              hc_flush_out
);

   localparam logic [HC_CNT_W-1:0] c_CNT_LOAD = HC_CNT_W'(FLUSH_CYCLES - 1);
   localparam logic                c_MULTI    = (FLUSH_CYCLES > 1);

   hc_state_t           r_state;
   hc_state_t           w_next;
   logic [HC_CNT_W-1:0] r_cnt;
   logic [HC_CNT_W-1:0] w_cnt_next;

   logic              w_busy;
   logic              w_strobe;
   logic [ADDR_W-1:0] w_addr;
   logic              w_ack;
   logic              w_flush;
   logic              w_start;
   logic              w_cap;
   logic              w_clr;
   logic              w_pend_valid;
   logic [ADDR_W-1:0] w_pend_addr;

   assign w_busy = hc_mem_busy_in | hc_div_busy_in;

   hold_ctrl_redir_buf #(
      .ADDR_W (ADDR_W)
   ) u_redir_buf (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_cap),
      .i_addr  (hc_jump_addr_in),
      .i_clear (w_clr),
      .o_valid (w_pend_valid),
      .o_addr  (w_pend_addr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= HC_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_strobe   = 1'b0;
      w_addr     = '0;
      w_ack      = 1'b0;
      w_flush    = 1'b0;
      w_start    = 1'b0;
      w_cap      = 1'b0;
      w_clr      = 1'b0;
      case (r_state)
         HC_RUN: begin
            // A jump beats a simultaneous irq; the irq level stays up and is taken later.
            if (hc_jump_flag_in) begin
               if (w_busy) begin
                  w_cap  = 1'b1;
                  w_next = HC_PEND;
               end else begin
                  w_strobe = 1'b1;
                  w_addr   = hc_jump_addr_in;
                  w_start  = 1'b1;
               end
            end else if (hc_irq_flag_in && !w_busy) begin
               w_strobe = 1'b1;
               w_addr   = hc_irq_addr_in;
               w_ack    = 1'b1;
               w_start  = 1'b1;
            end
         end
         HC_FLUSH: begin
            if (!w_busy) begin
               w_flush    = 1'b1;
               w_cnt_next = r_cnt - 1'b1;
               if (r_cnt <= 1) begin
                  w_next = HC_RUN;
               end
            end
         end
         HC_PEND: begin
            if (!w_busy) begin
               w_strobe = w_pend_valid;
               w_addr   = w_pend_addr;
               w_clr    = 1'b1;
               w_start  = 1'b1;
               w_next   = HC_RUN;
            end
         end
         default: begin
            w_next = HC_RUN;
         end
      endcase
      // The issue cycle is the first bubble of the window.
      if (w_start) begin
         w_flush = 1'b1;
         if (c_MULTI) begin
            w_cnt_next = c_CNT_LOAD;
            w_next     = HC_FLUSH;
         end
      end
   end

   assign hc_jump_flag_out = w_strobe & ~rst;
   assign hc_jump_addr_out = (w_strobe && !rst) ? w_addr : '0;
   assign hc_irq_ack_out   = w_ack & ~rst;
   assign hc_flush_out     = w_flush & ~rst & ~w_busy;
   assign hc_hold_pc_out   = w_busy;
   assign hc_hold_if_out   = w_busy;
   assign hc_hold_id_out   = w_busy;

endmodule : hold_ctrl
`default_nettype wire

// File: tb/tb_hold_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hold_ctrl : directed scenarios plus random traffic vs. a redirect  |
// |                queue / bubble-count model. Rev 1.0                    |
// +----------------------------------------------------------------------+
module tb_hold_ctrl;

   localparam int c_F = 2;

   logic        clk;
   logic        rst;
   logic        jf;
   logic [31:0] ja;
   logic        irq_f;
   logic [31:0] irq_a;
   logic        mb;
   logic        db;
   logic        o_ack;
   logic        o_str;
   logic [31:0] o_addr;
   logic        o_hpc;
   logic        o_hif;
   logic        o_hid;
   logic        o_fl;

   int          n_vec;
   int          n_err;
   int          bub;
   logic [31:0] pq[$];
   logic        e_ack;

   hold_ctrl #(
      .FLUSH_CYCLES (c_F),
      .ADDR_W       (32)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .hc_jump_flag_in  (jf),
      .hc_jump_addr_in  (ja),
      .hc_irq_flag_in   (irq_f),
      .hc_irq_addr_in   (irq_a),
      .hc_irq_ack_out   (o_ack),
      .hc_mem_busy_in   (mb),
      .hc_div_busy_in   (db),
      .hc_jump_flag_out (o_str),
      .hc_jump_addr_out (o_addr),
      .hc_hold_pc_out   (o_hpc),
      .hc_hold_if_out   (o_hif),
      .hc_hold_id_out   (o_hid),
      .hc_flush_out     (o_fl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive, predict from the model, compare mid-cycle, then advance the model.
   task automatic step(input logic r, input logic j, input logic [31:0] a,
                       input logic m, input logic d);
      logic        busy;
      logic        launch;
      logic        push;
      logic        pop;
      logic        e_str;
      logic        e_fl;
      logic [31:0] e_addr;
      rst = r; jf = j; ja = a; mb = m; db = d;
      busy   = m | d;
      e_str  = 1'b0;
      e_ack  = 1'b0;
      e_fl   = 1'b0;
      e_addr = '0;
      launch = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
      if (!r) begin
         if (bub > 0) begin
            e_fl = !busy;
         end else if (pq.size() > 0) begin
            if (!busy) begin
               e_str = 1'b1; e_addr = pq[0]; launch = 1'b1; pop = 1'b1;
            end
         end else if (j) begin
            if (busy) push = 1'b1;
            else begin
               e_str = 1'b1; e_addr = a; launch = 1'b1;
            end
         end else if (irq_f && !busy) begin
            e_str = 1'b1; e_addr = irq_a; e_ack = 1'b1; launch = 1'b1;
         end
         if (launch) e_fl = 1'b1;
      end
      #2;
      chk("strobe",  32'(o_str), 32'(e_str));
      chk("addr",    o_addr,     e_addr);
      chk("ack",     32'(o_ack), 32'(e_ack));
      chk("flush",   32'(o_fl),  32'(e_fl));
      chk("hold_pc", 32'(o_hpc), 32'(busy));
      chk("hold_if", 32'(o_hif), 32'(busy));
      chk("hold_id", 32'(o_hid), 32'(busy));
      @(posedge clk);
      if (r) begin
         bub = 0;
         pq.delete();
      end else begin
         if (bub > 0 && !busy) bub--;
         if (pop) void'(pq.pop_front());
         if (push) pq.push_back(a);
         if (launch) bub = c_F - 1;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; bub = 0;
      rst = 1'b1; jf = 1'b0; ja = '0; irq_f = 1'b0; irq_a = '0; mb = 1'b0; db = 1'b0;
      e_ack = 1'b0;
      @(posedge clk);
      #1;

      // Reset with a jump asserted, then quiet
      step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
      idle(2);

      // Plain jump
      step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
      idle(3);

      // Jump under mem_busy
      step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      idle(3);

      // Jump and irq together; irq taken after the window
      irq_f = 1'b1; irq_a = 32'h8000_0000;
      step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
      idle(1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("t4_ack_seen", 32'(e_ack), 32'd1);
      irq_f = 1'b0;
      idle(3);

      // Divider stall inside the flush window
      step(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      idle(3);

      // Reset discards a buffered redirect
      step(1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
      step(1'b1, 1'b0, 32'h0,   1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
      idle(3);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         if (!irq_f && ($urandom % 10 == 0)) begin
            irq_f = 1'b1;
            irq_a = $urandom;
         end
         step(($urandom % 64) == 0, ($urandom % 5) == 0, $urandom,
              ($urandom % 4) == 0, ($urandom % 6) == 0);
         if (e_ack) irq_f = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_hold_ctrl
`default_nettype wire
